// File: rtl/cache_miss_handler_if.sv
// Signal bundle between cache control / arrays / memory port and cache_miss_handler.
// miss_count and wb_count exist only when CACHE_MISS_HANDLER_STATS_EN is defined.
interface cache_miss_handler_if #(
    parameter int s_index    = 4,
    parameter int s_tag      = 23,
    parameter int beat_width = 64,
    parameter int num_beats  = 4
);
    logic                              miss_req;
    logic [31:0]                       miss_addr;
    logic [1:0]                        victim_way;
    logic                              victim_valid;
    logic                              victim_dirty;
    logic [s_tag-1:0]                  victim_tag;
    logic [beat_width*num_beats-1:0]   line_rdata;
    logic                              busy;
    logic                              done;
    logic [1:0]                        way_sel;
    logic [s_index-1:0]                index;
    logic                              data_we;
    logic [beat_width*num_beats-1:0]   line_wdata;
    logic                              tag_we;
    logic [s_tag-1:0]                  tag_wdata;
    logic                              load_plru;
    logic                              mem_read;
    logic                              mem_write;
    logic [31:0]                       mem_addr;
    logic [beat_width-1:0]             mem_wdata;
    logic [beat_width-1:0]             mem_rdata;
    logic                              mem_resp;
`ifdef CACHE_MISS_HANDLER_STATS_EN
    logic [31:0]                       miss_count;
    logic [31:0]                       wb_count;
`endif

    modport master (
        output miss_req, miss_addr, victim_way, victim_valid, victim_dirty, victim_tag,
        output line_rdata, mem_rdata, mem_resp,
`ifdef CACHE_MISS_HANDLER_STATS_EN
        input  miss_count, wb_count,
`endif
        input  busy, done, way_sel, index, data_we, line_wdata, tag_we, tag_wdata,
        input  load_plru, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  miss_req, miss_addr, victim_way, victim_valid, victim_dirty, victim_tag,
        input  line_rdata, mem_rdata, mem_resp,
`ifdef CACHE_MISS_HANDLER_STATS_EN
        output miss_count, wb_count,
`endif
        output busy, done, way_sel, index, data_we, line_wdata, tag_we, tag_wdata,
        output load_plru, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_miss_handler.sv
// Miss service: optional victim writeback, 4-beat line fill, tag/data install, PLRU pulse.
// Latency: miss_req to done = 2 + fill resp cycles (+ writeback resp cycles when victim dirty).
// Backpressure: memory stalls by withholding mem_resp; miss_req ignored while busy. Option: CACHE_MISS_HANDLER_STATS_EN.
module cache_miss_handler #(
    parameter int s_index    = 4,
    parameter int s_offset   = 5,
    parameter int s_tag      = 23,
    parameter int beat_width = 64,
    parameter int num_beats  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_miss_handler_if.slave  bus
);
    localparam int              line_w    = beat_width * num_beats;
    localparam int              cnt_w     = $clog2(num_beats);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

    typedef enum logic [2:0] {IDLE, LATCH, WB, FILL, COMMIT} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [cnt_w-1:0]    r_cnt;
    logic [s_index-1:0]  r_index;
    logic [s_tag-1:0]    r_fill_tag;
    logic [s_tag-1:0]    r_victim_tag;
    logic [1:0]          r_way;
    logic                r_victim_wb;
    logic [line_w-1:0]   r_line;

    logic                w_accept;
    logic                w_beat;
    logic                w_commit;
    logic                w_mem_read;
    logic                w_mem_write;
    logic [31:0]         w_mem_addr;
    logic                w_unused_addr_bits;

    assign w_unused_addr_bits = ^bus.miss_addr[s_offset-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        w_commit    = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = '0;
        case (r_state)
            IDLE: begin
                if (bus.miss_req) begin
                    w_accept = 1'b1;
                    w_next   = LATCH;
                end
            end
            LATCH: w_next = r_victim_wb ? WB : FILL;
            WB: begin
                w_mem_write = 1'b1;
                w_mem_addr  = {r_victim_tag, r_index, {s_offset{1'b0}}};
                w_beat      = bus.mem_resp;
                if (w_beat && r_cnt == last_beat) w_next = FILL;
            end
            FILL: begin
                w_mem_read = 1'b1;
                w_mem_addr = {r_fill_tag, r_index, {s_offset{1'b0}}};
                w_beat     = bus.mem_resp;
                if (w_beat && r_cnt == last_beat) w_next = COMMIT;
            end
            COMMIT: begin
                w_commit = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Victim line is captured whole in LATCH, then overwritten beat by beat during FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_index      <= '0;
            r_fill_tag   <= '0;
            r_victim_tag <= '0;
            r_way        <= '0;
            r_victim_wb  <= 1'b0;
            r_line       <= '0;
        end else begin
            if (w_accept) begin
                r_index      <= bus.miss_addr[s_offset+s_index-1:s_offset];
                r_fill_tag   <= bus.miss_addr[31:32-s_tag];
                r_way        <= bus.victim_way;
                r_victim_wb  <= bus.victim_valid & bus.victim_dirty;
                r_victim_tag <= bus.victim_tag;
            end
            if (r_state == LATCH) r_line <= bus.line_rdata;
            if (w_beat) begin
                r_cnt <= (r_cnt == last_beat) ? '0 : r_cnt + 1'b1;
                if (r_state == FILL) r_line[r_cnt*beat_width +: beat_width] <= bus.mem_rdata;
            end
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = w_commit;
    assign bus.data_we    = w_commit;
    assign bus.tag_we     = w_commit;
    assign bus.load_plru  = w_commit;
    assign bus.way_sel    = r_way;
    assign bus.index      = r_index;
    assign bus.line_wdata = w_commit ? r_line : '0;
    assign bus.tag_wdata  = w_commit ? r_fill_tag : '0;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_write ? r_line[r_cnt*beat_width +: beat_width] : '0;

`ifdef CACHE_MISS_HANDLER_STATS_EN
    logic [31:0] r_miss_count;
    logic [31:0] r_wb_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (w_accept && r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
            if (r_state == LATCH && r_victim_wb && r_wb_count != '1) r_wb_count <= r_wb_count + 1'b1;
        end
    end

    assign bus.miss_count = r_miss_count;
    assign bus.wb_count   = r_wb_count;
`endif
endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: table of miss scenarios plus busy-request and async-reset sequences.
module tb_cache_miss_handler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_miss_handler_if bus ();
    cache_miss_handler dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [31:0]  addr;
        logic [1:0]   way;
        logic         valid;
        logic         dirty;
        logic [22:0]  vtag;
        logic [255:0] line;
        int           period;
        logic         junk;
        int           exp_lat;
        int           exp_wb;
        logic [31:0]  exp_wb_addr;
        logic [31:0]  exp_fill_addr;
        logic [3:0]   exp_idx;
        logic [22:0]  exp_tag;
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc, g_period, g_phase, g_id, wb_cnt, fill_cnt, wb_bad, addr_bad, both_hi;
    logic         g_junk;
    logic [255:0] g_line;
    logic [31:0]  g_wb_addr, g_fill_addr;

    function automatic logic [63:0] fill_beat(input int id, input int k);
        return {32'hF111_0000 | 32'(id), 32'hBEA7_0000 | 32'(k)};
    endfunction

    function automatic logic [255:0] fill_line(input int id);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = fill_beat(id, k);
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: advance past the edge, then play the memory side for the coming edge.
    task automatic step();
        logic resp;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mem_read && bus.mem_write) both_hi++;
        if (bus.mem_write && bus.mem_addr !== g_wb_addr) addr_bad++;
        if (bus.mem_read && bus.mem_addr !== g_fill_addr) addr_bad++;
        if (bus.mem_read || bus.mem_write) begin
            if (g_phase == g_period - 1) begin resp = 1'b1; g_phase = 0; end
            else begin resp = 1'b0; g_phase++; end
        end else begin
            resp = g_junk;
        end
        bus.mem_resp  = resp;
        bus.mem_rdata = resp ? (bus.mem_read ? fill_beat(g_id, fill_cnt % 4) : 64'hDEAD_DEAD_DEAD_DEAD) : 64'h0;
        if (resp && bus.mem_write) begin
            if (bus.mem_wdata !== g_line[64*(wb_cnt%4) +: 64]) wb_bad++;
            wb_cnt++;
        end
        if (resp && bus.mem_read) fill_cnt++;
    endtask

    task automatic setup(input int i);
        g_period = vecs[i].period; g_phase = 0; g_id = i; g_junk = vecs[i].junk;
        g_line = vecs[i].line; g_wb_addr = vecs[i].exp_wb_addr; g_fill_addr = vecs[i].exp_fill_addr;
        wb_cnt = 0; fill_cnt = 0; wb_bad = 0; addr_bad = 0; both_hi = 0; cyc = 0;
        bus.miss_req     = 1'b1;
        bus.miss_addr    = vecs[i].addr;
        bus.victim_way   = vecs[i].way;
        bus.victim_valid = vecs[i].valid;
        bus.victim_dirty = vecs[i].dirty;
        bus.victim_tag   = vecs[i].vtag;
        bus.line_rdata   = vecs[i].line;
        bus.mem_resp     = vecs[i].junk;
        bus.mem_rdata    = '0;
    endtask

    task automatic run_vec(input int i);
        int done_cyc = -1;
        setup(i);
        while (done_cyc < 0 && cyc < 100) begin
            step();
            if (cyc == 1) begin
                chk($sformatf("v%0d latch_busy", i), bus.busy, 1'b1);
                chk($sformatf("v%0d latch_way", i), bus.way_sel, vecs[i].way);
                chk($sformatf("v%0d latch_index", i), bus.index, vecs[i].exp_idx);
                chk($sformatf("v%0d latch_no_mem", i), bus.mem_read | bus.mem_write, 1'b0);
            end
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                bus.miss_req = 1'b0;
                chk($sformatf("v%0d data_we", i), bus.data_we, 1'b1);
                chk($sformatf("v%0d tag_we", i), bus.tag_we, 1'b1);
                chk($sformatf("v%0d load_plru", i), bus.load_plru, 1'b1);
                chk($sformatf("v%0d line_wdata", i), bus.line_wdata, fill_line(i));
                chk($sformatf("v%0d tag_wdata", i), bus.tag_wdata, vecs[i].exp_tag);
                chk($sformatf("v%0d commit_way", i), bus.way_sel, vecs[i].way);
                chk($sformatf("v%0d commit_index", i), bus.index, vecs[i].exp_idx);
            end
        end
        chk($sformatf("v%0d latency", i), done_cyc, vecs[i].exp_lat);
        chk($sformatf("v%0d wb_beats", i), wb_cnt, vecs[i].exp_wb);
        chk($sformatf("v%0d wb_data_errs", i), wb_bad, 0);
        chk($sformatf("v%0d fill_beats", i), fill_cnt, 4);
        chk($sformatf("v%0d addr_errs", i), addr_bad, 0);
        chk($sformatf("v%0d rd_wr_overlap", i), both_hi, 0);
        step();
        chk($sformatf("v%0d idle_busy", i), bus.busy, 1'b0);
        chk($sformatf("v%0d idle_done", i), bus.done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int done_cyc;
        vecs[0] = '{32'h0000_1240, 2'd1, 1'b0, 1'b1, 23'h55, {4{64'hC1EA_0000_0000_0001}},
                    1, 1'b0, 6, 0, 32'h0, 32'h0000_1240, 4'd2, 23'h9};
        vecs[1] = '{32'h0000_5440, 2'd2, 1'b1, 1'b1, 23'h1,
                    {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
                    1, 1'b0, 10, 4, 32'h0000_0240, 32'h0000_5440, 4'd2, 23'h2A};
        vecs[2] = '{32'hABCD_E0F7, 2'd3, 1'b1, 1'b0, 23'h7ABCD,
                    {64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001, 64'h0000_0000_0000_0000},
                    3, 1'b0, 14, 0, 32'h0, 32'hABCD_E0E0, 4'd7, 23'h55E6F0};
        vecs[3] = '{32'h8000_01FF, 2'd0, 1'b1, 1'b1, 23'h7FFFFF,
                    {64'hD3D3_0000_1111_0003, 64'hD2D2_0000_1111_0002, 64'hD1D1_0000_1111_0001, 64'hD0D0_0000_1111_0000},
                    3, 1'b1, 26, 4, 32'hFFFF_FFE0, 32'h8000_01E0, 4'd15, 23'h400000};
        vecs[4] = '{32'h0000_0000, 2'd1, 1'b1, 1'b0, 23'h123, {4{64'h5A5A_5A5A_0F0F_0F0F}},
                    2, 1'b1, 10, 0, 32'h0, 32'h0000_0000, 4'd0, 23'h0};

        bus.miss_req = 1'b0; bus.miss_addr = '0; bus.victim_way = '0; bus.victim_valid = 1'b0;
        bus.victim_dirty = 1'b0; bus.victim_tag = '0; bus.line_rdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0;
        g_period = 1; g_phase = 0; g_junk = 1'b0; g_line = '0; g_wb_addr = '0; g_fill_addr = '0;

        #12;
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst mem_read", bus.mem_read, 1'b0);
        chk("rst mem_write", bus.mem_write, 1'b0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 64'h0);
        chk("rst data_we", bus.data_we, 1'b0);
        chk("rst tag_we", bus.tag_we, 1'b0);
        chk("rst load_plru", bus.load_plru, 1'b0);
        chk("rst way_sel", bus.way_sel, 2'd0);
        chk("rst index", bus.index, 4'd0);
        chk("rst line_wdata", bus.line_wdata, 256'h0);
        chk("rst tag_wdata", bus.tag_wdata, 23'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Second request pulsed mid-FILL is ignored; a request held after done is taken next cycle.
        setup(0);
        done_cyc = -1;
        while (cyc < 30 && done_cyc < 0) begin
            step();
            if (cyc == 1) bus.miss_req = 1'b0;
            if (cyc == 3) begin
                bus.miss_req  = 1'b1;
                bus.miss_addr = 32'h0000_3FE0;
            end
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                chk("busyreq first_tag", bus.tag_wdata, 23'h9);
            end
        end
        chk("busyreq done_cycle", done_cyc, 6);
        step();
        chk("busyreq idle_busy", bus.busy, 1'b0);
        chk("busyreq idle_done", bus.done, 1'b0);
        step();
        chk("heldreq accepted", bus.busy, 1'b1);
        chk("heldreq index", bus.index, 4'd15);
        bus.miss_req = 1'b0;
        g_fill_addr = 32'h0000_3FE0;
        k = 0;
        while (k < 30 && bus.done !== 1'b1) begin
            step();
            k++;
        end
        chk("heldreq done", bus.done, 1'b1);
        chk("heldreq tag", bus.tag_wdata, 23'h1F);
        step();

        // Async reset between edges, two writeback beats into a dirty miss.
        setup(1);
        step();
        step();
        step();
        step();
        chk("arst pre_wb", bus.mem_write, 1'b1);
        chk("arst pre_wb_data", wb_bad, 0);
        bus.miss_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst mem_write", bus.mem_write, 1'b0);
        chk("arst mem_read", bus.mem_read, 1'b0);
        chk("arst busy", bus.busy, 1'b0);
        chk("arst mem_addr", bus.mem_addr, 32'h0);
        chk("arst mem_wdata", bus.mem_wdata, 64'h0);
        chk("arst way_sel", bus.way_sel, 2'd0);
        chk("arst index", bus.index, 4'd0);
        bus.mem_resp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
